// File: rtl/gating_topk_router_if.sv
// Ready/valid bundle for the Top-K router: logit beats in, ranked
// (score, expert-id) entries out.
interface gating_topk_router_if #(
  parameter int LANES = 16,
  parameter int DW    = 16,
  parameter int IDW   = 7
);
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_vec;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_score;
  logic [IDW-1:0]      out_id;
  logic                out_last;

  modport master (
    output in_valid, in_vec, in_last, out_ready,
    input  in_ready, out_valid, out_score, out_id, out_last
  );

  modport slave (
    input  in_valid, in_vec, in_last, out_ready,
    output in_ready, out_valid, out_score, out_id, out_last
  );
endinterface

// File: rtl/gating_topk_router.sv
// Streaming Top-K router: serialises FP16 logit beats into a sorted
// K-entry list and emits the winners highest-first.
module gating_topk_router #(
  parameter int LANES = 16,
  parameter int DW    = 16,
  parameter int KMAX  = 8,
  parameter int KW    = 3,
  parameter int IDW   = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] cfg_k,
  gating_topk_router_if.slave bus,
  output logic          busy,
  output logic          err_ovf
);
  localparam int LW = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, EMIT} state_e;

  state_e              state_q, state_d;
  logic [LANES*DW-1:0] beat_q;
  logic                last_q;
  logic [LW-1:0]       lane_q;
  logic [IDW-1:0]      cnt_q;
  logic                sat_q, err_q;
  logic [KW-1:0]       k_q, e_q;

  logic [DW-1:0]   sc_q [KMAX];
  logic [DW-1:0]   sc_d [KMAX];
  logic [IDW-1:0]  id_q [KMAX];
  logic [IDW-1:0]  id_d [KMAX];
  logic [KMAX-1:0] v_q, v_d, gt, gt_prev;

  logic          acc, scan_en, take, emit_hs;
  logic [DW-1:0] new_s, new_k;

  // Monotone unsigned rank of an FP16 value; NaN sinks to the bottom.
  function automatic logic [DW-1:0] key_f(input logic [DW-1:0] s);
    if (s[14:10] == 5'h1f && s[9:0] != 10'd0) return '0;
    return s[DW-1] ? ~s : (s | {1'b1, {(DW-1){1'b0}}});
  endfunction

  assign acc     = bus.in_valid && (state_q == LOAD) && !start;
  assign scan_en = (state_q == SCAN) && !start;
  assign take    = scan_en && !sat_q;
  assign emit_hs = bus.out_valid && bus.out_ready && !start;
  assign new_s   = beat_q[DW-1:0];
  assign new_k   = key_f(new_s);

  always_comb begin
    gt = '0;
    for (int i = 0; i < KMAX; i++) begin
      gt[i] = (KW'(i) <= k_q) &&
              (!v_q[i] || new_k > key_f(sc_q[i]));
    end
  end

  assign gt_prev = {gt[KMAX-2:0], 1'b0};

  // Insert at the first displaced slot; everything below moves down.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < KMAX; i++) begin
      sc_d[i] = sc_q[i];
      id_d[i] = id_q[i];
    end
    if (start) begin
      v_d = '0;
    end else if (take) begin
      for (int i = 0; i < KMAX; i++) begin
        if (gt[i] && !gt_prev[i]) begin
          sc_d[i] = new_s;
          id_d[i] = cnt_q;
          v_d[i]  = 1'b1;
        end
      end
      for (int i = 1; i < KMAX; i++) begin
        if (gt[i] && gt_prev[i]) begin
          sc_d[i] = sc_q[i-1];
          id_d[i] = id_q[i-1];
          v_d[i]  = v_q[i-1];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = IDLE;
      LOAD: if (acc) state_d = SCAN;
      SCAN: if (lane_q == LW'(LANES-1))
              state_d = last_q ? EMIT : LOAD;
      EMIT: if (emit_hs && bus.out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) state_d = LOAD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      last_q  <= 1'b0;
      lane_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
      e_q     <= '0;
      v_q     <= '0;
      for (int i = 0; i < KMAX; i++) begin
        sc_q[i] <= '0;
        id_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      for (int i = 0; i < KMAX; i++) begin
        sc_q[i] <= sc_d[i];
        id_q[i] <= id_d[i];
      end
      if (start) begin
        k_q   <= cfg_k;
        cnt_q <= '0;
        sat_q <= 1'b0;
        err_q <= 1'b0;
        e_q   <= '0;
      end else begin
        if (acc) begin
          beat_q <= bus.in_vec;
          last_q <= bus.in_last;
          lane_q <= '0;
        end
        if (scan_en) begin
          beat_q <= beat_q >> DW;
          lane_q <= lane_q + 1'b1;
          if (sat_q)             err_q <= 1'b1;
          else if (&cnt_q)       sat_q <= 1'b1;
          else                   cnt_q <= cnt_q + 1'b1;
        end
        if (emit_hs) e_q <= e_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_score = bus.out_valid ? sc_q[e_q] : '0;
  assign bus.out_id    = bus.out_valid ? id_q[e_q] : '0;
  assign bus.out_last  = bus.out_valid && (e_q == k_q);
  assign busy          = (state_q != IDLE);
  assign err_ovf       = err_q;
endmodule
